ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
Target side of the byte-wide RAM bus driven by the CPU memory controller. Decodes each cycle's address and write flag and serves a synchronous byte RAM or a small memory-mapped IO window. The IO window has a TX byte FIFO streaming to the host/UART and an RX byte FIFO fed by the host. It sits between the core's memory controller and the board RAM/UART, and stands in as the simulation memory model.

Parameters:
RAM_AW, 17, RAM byte-address width (2^RAM_AW bytes)
FIFO_AW, 3, log2 depth of the TX and RX FIFOs (depth 8)
INIT_FILE, "", hex image loaded into RAM at elaboration; empty means no preload

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes all state
bus_a  in  32  byte address from the controller; bits 17:0 decoded
bus_wr  in  1  1 = write this cycle, 0 = read
bus_wdata  in  8  write byte
bus_rdata  out  8  read byte, registered, valid one cycle after the address
tx_data  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  host accepts tx_data this cycle
rx_data  in  8  byte from host
rx_valid  in  1  host offers rx_data
rx_ready  out  1  RX FIFO not full
sim_halt  out  1  sticky program-end flag

Behaviour:
- Reset and clock edge
  - Clock is clk. Reset is synchronous, active-high.
  - Reset clears: bus_rdata=0, both FIFOs empty (tx_valid=0, rx_ready=1), sim_halt=0, the rx-pop edge flag, and the last-address register.
  - RAM contents are not cleared.
  - Reset mid-transaction discards queued FIFO bytes.
- rdy=0: no RAM write, no FIFO push/pop from the bus side, bus_rdata holds. Host-side handshakes also stall: tx_ready and rx_valid are ignored.
- Decode:
  - io_sel = (bus_a[17:16]==2'b11).
  - Otherwise RAM at index bus_a[RAM_AW-1:0].
  - IO registers: IO_DATA=0x30000, IO_STAT=0x30004, IO_HALT=0x30008. All other IO offsets read 0 and ignore writes.
- RAM write: bus_wr=1 and !io_sel writes bus_wdata to RAM in the same edge. A burst of consecutive write cycles at incrementing addresses is simply consecutive byte writes.
- Read latency: exactly 1 cycle. Address presented in cycle N gives bus_rdata valid in cycle N+1. The controller samples bus_rdata one cycle after driving the address.
- Read-during-write to the same RAM address: bus_rdata returns the old byte.
- IO_DATA write: pushes bus_wdata into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and a sticky tx_overflow internal flag is set (visible in status bit 2).
- IO_DATA read:
  - bus_rdata = RX head, or 0 if the RX FIFO is empty.
  - Pops one byte only on the first qualifying cycle: rdy=1, !bus_wr, bus_a==IO_DATA, and the previous rdy cycle did not satisfy the same condition.
  - A held address therefore pops once. Leaving the address and returning pops again.
- IO_STAT read returns {5'b0, tx_overflow, tx_full, rx_nonempty}. IO_STAT+1..+3 read 0. Reads of IO_STAT have no side effect.
- IO_HALT write of any value sets sim_halt=1. It stays set until rst.
- TX FIFO:
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop at full is allowed: count unchanged, no overflow.
- RX FIFO:
  - Push when rx_valid && rx_ready.
  - Simultaneous host push and bus pop when full is allowed.
  - Pop of an empty FIFO is a no-op.
- FIFO pointers: FIFO_AW+1 bits, wrap naturally. full = MSBs differ and lower bits equal. empty = pointers equal.

Decomposition:
- Shared package/defines: IO_DATA, IO_STAT, IO_HALT address constants; IO_SEL value 2'b11; status bit positions.
- One sub-module, byte_fifo (params AW, width 8; push/pop/full/empty/head), instantiated for TX and RX.
- RAM array and decode stay in ram_io_responder.

Test Plan:
- Write 0xA5 to 0x00010, next cycle read 0x00010 -> bus_rdata=0xA5 exactly one cycle after the address.
- 4-byte burst write 0x11,0x22,0x33,0x44 to 0x100..0x103, then burst read -> bytes return in order, one per cycle, 1-cycle latency.
- Nine writes to IO_DATA with tx_ready=0 -> tx_valid=1, IO_STAT reads 0x06. Raise tx_ready -> bytes 1..8 appear in order, 9th lost.
- Host pushes 0x5A, bus holds IO_DATA read for 3 cycles -> bus_rdata=0x5A, exactly one pop, IO_STAT then reads 0x00.
- rdy=0 during a write to 0x20 with data 0xFF -> RAM[0x20] unchanged, bus_rdata held.
- Write 0x00 to IO_HALT -> sim_halt=1 next cycle. Pulse rst -> sim_halt=0, tx_valid=0, bus_rdata=0.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg
// Shared constants for the RAM/IO responder: IO register addresses, the IO
// window select value, status-byte bit positions, and an IO address decoder.
package ram_io_responder_pkg;

    // IO register addresses as seen on bus_a[17:0]
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_STAT = 18'h30004;
    localparam logic [17:0] IO_HALT = 18'h30008;

    // bus_a[17:16] value that selects the IO window instead of RAM
    localparam logic [1:0] IO_SEL = 2'b11;

    // IO_STAT bit positions
    localparam int unsigned STAT_RX_NONEMPTY = 0;
    localparam int unsigned STAT_TX_FULL     = 1;
    localparam int unsigned STAT_TX_OVERFLOW = 2;

    typedef enum logic [1:0] {
        IoNone,
        IoData,
        IoStat,
        IoHalt
    } io_reg_e;

    // Any IO-window offset that is not a named register decodes to IoNone.
    function automatic io_reg_e decode_io(input logic [17:0] addr);
        case (addr)
            IO_DATA: return IoData;
            IO_STAT: return IoStat;
            IO_HALT: return IoHalt;
            default: return IoNone;
        endcase
    endfunction

    function automatic logic [7:0] stat_byte(input logic tx_overflow,
                                             input logic tx_full,
                                             input logic rx_nonempty);
        logic [7:0] s;
        s                   = 8'h00;
        s[STAT_TX_OVERFLOW] = tx_overflow;
        s[STAT_TX_FULL]     = tx_full;
        s[STAT_RX_NONEMPTY] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// ram_io_responder_byte_fifo
// Synchronous FIFO with AW+1-bit wrapping pointers, used for both the TX and
// RX byte streams of the responder.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write din when push (accepted if not full, or if a pop
//                happens in the same cycle)
//   pop        : remove head when pop and not empty; popping empty is a no-op
//   head       : current head entry (undefined content when empty)
//   full/empty : occupancy flags
module ram_io_responder_byte_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A push at full is still taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder
// Target side of the byte-wide RAM bus. Each cycle decodes bus_a/bus_wr and
// serves either a synchronous byte RAM or a small IO window holding a TX byte
// FIFO (to host/UART), an RX byte FIFO (from host), a status register and a
// sticky halt flag.
//   clk, rst           : clock, synchronous active-high reset
//   rdy                : global enable; 0 freezes all state incl. host handshakes
//   bus_a, bus_wr      : byte address (bits 17:0 decoded) and write flag
//   bus_wdata          : write byte
//   bus_rdata          : registered read byte, valid one cycle after the address
//   tx_data/valid/ready: TX FIFO head stream to the host
//   rx_data/valid/ready: RX byte stream from the host into the RX FIFO
//   sim_halt           : set by any write to IO_HALT, cleared only by rst
module ram_io_responder #(
    parameter int unsigned RAM_AW    = 17,
    parameter int unsigned FIFO_AW   = 3,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_halt
);

    import ram_io_responder_pkg::*;

    // Address decode
    logic [17:0]       dec_a;
    logic              unused_a_hi;
    logic              io_sel;
    io_reg_e           io_reg;
    logic [RAM_AW-1:0] ram_idx;

    assign dec_a       = bus_a[17:0];
    assign unused_a_hi = ^bus_a[31:18];
    assign io_sel      = (dec_a[17:16] == IO_SEL);
    assign io_reg      = io_sel ? decode_io(dec_a) : IoNone;
    assign ram_idx     = bus_a[RAM_AW-1:0];

    // Byte RAM
    logic [7:0] mem [2**RAM_AW];

    logic ram_we;
    assign ram_we = rdy && bus_wr && !io_sel;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= bus_wdata;
    end

    // IO side effects
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       data_rd;      // this cycle is a qualifying IO_DATA read
    logic       data_rd_q;    // previous rdy cycle was a qualifying IO_DATA read
    logic       halt_set;
    logic       tx_overflow;

    assign tx_push  = rdy && bus_wr && (io_reg == IoData);
    assign tx_pop   = rdy && tx_ready && !tx_empty;
    assign halt_set = rdy && bus_wr && (io_reg == IoHalt);
    assign data_rd  = rdy && !bus_wr && (io_reg == IoData);
    // Only the first cycle of a held IO_DATA read consumes a byte.
    assign rx_pop   = data_rd && !data_rd_q && !rx_empty;
    assign rx_push  = rdy && rx_valid && !rx_full;

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    ram_io_responder_byte_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus_wdata),
        .pop   (tx_pop),
        .head  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    ram_io_responder_byte_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Read mux; on a RAM write cycle this picks up the old byte.
    logic [7:0] rdata_next;

    always_comb begin
        rdata_next = 8'h00;
        if (!io_sel) begin
            rdata_next = mem[ram_idx];
        end else begin
            case (io_reg)
                IoData:  rdata_next = rx_empty ? 8'h00 : rx_head;
                IoStat:  rdata_next = stat_byte(tx_overflow, tx_full, !rx_empty);
                default: rdata_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata   <= 8'h00;
            data_rd_q   <= 1'b0;
            sim_halt    <= 1'b0;
            tx_overflow <= 1'b0;
        end else if (rdy) begin
            bus_rdata <= rdata_next;
            data_rd_q <= data_rd;
            if (halt_set) sim_halt <= 1'b1;
            // Dropped only when full and the host is not draining this cycle.
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
// Directed stimulus; expected read bytes and TX bytes are queued when issued
// and a separate monitor compares them when the DUT presents them.
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, sim_halt;

    localparam logic [31:0] A_DATA = 32'h0003_0000;
    localparam logic [31:0] A_STAT = 32'h0003_0004;
    localparam logic [31:0] A_HALT = 32'h0003_0008;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rd_exp_q[$];
    string      rd_name_q[$];
    logic [7:0] tx_exp_q[$];
    logic       rd_chk = 1'b0;
    logic       rd_pending = 1'b0;

    ram_io_responder dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .bus_a     (bus_a),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .sim_halt  (sim_halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read data one cycle after a checked read address, TX bytes on handshake.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(negedge clk);
            if (rd_pending) begin
                if (rd_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rdata_unexpected: got 0x%0h, expected nothing", bus_rdata);
                end else begin
                    e  = rd_exp_q.pop_front();
                    nm = rd_name_q.pop_front();
                    check(nm, {24'h0, bus_rdata}, {24'h0, e});
                end
            end
            rd_pending = rd_chk && rdy && !rst;
            if (tx_valid && tx_ready && rdy && !rst) begin
                if (tx_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
                end else begin
                    e = tx_exp_q.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                         input logic chk);
        @(posedge clk);
        #2;
        bus_a     = a;
        bus_wr    = wr;
        bus_wdata = wd;
        rd_chk    = chk;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        drive(a, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(a, 1'b0, 8'h00, 1'b1);
    endtask

    // Write cycle whose registered read-back (old byte) is also checked
    task automatic wr_rd(input logic [31:0] a, input logic [7:0] d, input logic [7:0] exp,
                         input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(a, 1'b1, d, 1'b1);
    endtask

    task automatic idle();
        drive(32'h10, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic host_push(input logic [7:0] d);
        @(posedge clk);
        #2;
        rx_valid = 1'b1;
        rx_data  = d;
    endtask

    task automatic host_stop();
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [4];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst       = 1'b1;
        rdy       = 1'b1;
        bus_a     = 32'h10;
        bus_wr    = 1'b0;
        bus_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", {24'h0, bus_rdata}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_sim_halt", {31'h0, sim_halt}, 32'h0);

        // Single write then read, plus read-during-write returning the old byte
        wr(32'h10, 8'hA5);
        rd(32'h10, 8'hA5, "ram_rd_0x10");
        wr_rd(32'h10, 8'h5C, 8'hA5, "ram_rdw_old");
        rd(32'h10, 8'h5C, "ram_rd_after_rdw");

        // Burst write then burst read
        for (int i = 0; i < 4; i++) wr(32'h100 + i, burst[i]);
        for (int i = 0; i < 4; i++) rd(32'h100 + i, burst[i], $sformatf("burst_rd_%0d", i));
        idle();

        // Nine TX pushes with host stalled: 8 kept, 9th dropped with overflow
        for (int i = 1; i <= 9; i++) wr(A_DATA, 8'(i));
        for (int i = 1; i <= 8; i++) tx_exp_q.push_back(8'(i));
        idle();
        @(negedge clk);
        check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
        rd(A_STAT, 8'h06, "stat_full_ovf");
        idle();
        @(posedge clk);
        #2;
        tx_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        tx_ready = 1'b0;
        @(negedge clk);
        check("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
        check("tx_queue_drained", tx_exp_q.size(), 32'h0);
        rd(A_STAT, 8'h04, "stat_ovf_sticky");
        idle();
        pulse_rst();

        // RX: one byte, IO_DATA held 3 cycles pops once
        host_push(8'h5A);
        host_stop();
        rd(A_DATA, 8'h5A, "rx_held_1");
        rd(A_DATA, 8'h00, "rx_held_2");
        rd(A_DATA, 8'h00, "rx_held_3");
        rd(A_STAT, 8'h00, "stat_rx_empty");
        idle();

        // Held address pops once; leaving and returning pops again
        host_push(8'h11);
        host_push(8'h22);
        host_stop();
        rd(A_DATA, 8'h11, "rx_edge_first");
        rd(A_DATA, 8'h22, "rx_edge_held");
        rd(A_STAT, 8'h01, "stat_rx_nonempty");
        rd(A_DATA, 8'h22, "rx_edge_return");
        rd(A_STAT, 8'h00, "stat_rx_empty_2");
        idle();

        // Fill RX FIFO
        for (int i = 0; i < 8; i++) host_push(8'h80 + 8'(i));
        host_stop();
        @(negedge clk);
        check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
        rd(A_DATA, 8'h80, "rx_full_head");
        rd(A_STAT, 8'h01, "stat_rx_after_pop");
        idle();
        @(negedge clk);
        check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);

        // rdy=0 blocks the RAM write and holds bus_rdata
        wr(32'h20, 8'h3C);
        rd(32'h20, 8'h3C, "ram_rd_0x20");
        @(posedge clk);
        #2;
        rdy       = 1'b0;
        bus_a     = 32'h20;
        bus_wr    = 1'b1;
        bus_wdata = 8'hFF;
        rd_chk    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rdy0_rdata_hold", {24'h0, bus_rdata}, 32'h3C);
        bus_wr = 1'b0;
        bus_a  = 32'h10;
        rdy    = 1'b1;
        rd(32'h20, 8'h3C, "rdy0_no_write");
        idle();

        // Halt and reset
        wr(A_HALT, 8'h00);
        @(negedge clk);
        check("halt_not_yet", {31'h0, sim_halt}, 32'h0);
        idle();
        @(negedge clk);
        check("halt_set", {31'h0, sim_halt}, 32'h1);
        wr(A_DATA, 8'h77);
        rd(32'h10, 8'h5C, "pre_rst_rd");
        idle();
        @(negedge clk);
        check("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("halt_sticky", {31'h0, sim_halt}, 32'h1);
        pulse_rst();
        @(negedge clk);
        check("post_rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        check("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("post_rst_rdata", {24'h0, bus_rdata}, 32'h0);
        check("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        rd(32'h10, 8'h5C, "ram_kept_after_rst");
        idle();
        idle();
        @(negedge clk);
        check("rd_queue_drained", rd_exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
